// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// alu_pkg : ALUOp, funct and ALU-control encodings for the execute stage
// Revision: 1.0
// ============================================================================
package alu_pkg;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;
   localparam logic [1:0] ALUOP_OR    = 2'b11;

   localparam logic [5:0] FUNCT_ADD = 6'h20;
   localparam logic [5:0] FUNCT_SUB = 6'h22;
   localparam logic [5:0] FUNCT_AND = 6'h24;
   localparam logic [5:0] FUNCT_OR  = 6'h25;
   localparam logic [5:0] FUNCT_NOR = 6'h27;
   localparam logic [5:0] FUNCT_SLT = 6'h2A;

   localparam logic [3:0] ALU_AND     = 4'b0000;
   localparam logic [3:0] ALU_OR      = 4'b0001;
   localparam logic [3:0] ALU_ADD     = 4'b0010;
   localparam logic [3:0] ALU_SUB     = 4'b0110;
   localparam logic [3:0] ALU_SLT     = 4'b0111;
   localparam logic [3:0] ALU_NOR     = 4'b1100;
   localparam logic [3:0] ALU_ILLEGAL = 4'b1111;

endpackage
`default_nettype wire

// File: rtl/alu_ctrl_decoder.sv
`default_nettype none
// ============================================================================
// alu_ctrl_decoder : maps main-control ALUOp and funct to the ALU control code
// Revision: 1.0
// ============================================================================
module alu_ctrl_decoder
   import alu_pkg::*;
(
   input  logic [1:0] alu_op,
   input  logic [5:0] funct,
   output logic [3:0] alu_ctrl
);

   always_comb begin
      alu_ctrl = ALU_ILLEGAL;
      case (alu_op)
         ALUOP_ADD: alu_ctrl = ALU_ADD;
         ALUOP_SUB: alu_ctrl = ALU_SUB;
         ALUOP_OR:  alu_ctrl = ALU_OR;
         ALUOP_RTYPE: begin
            case (funct)
               FUNCT_ADD: alu_ctrl = ALU_ADD;
               FUNCT_SUB: alu_ctrl = ALU_SUB;
               FUNCT_AND: alu_ctrl = ALU_AND;
               FUNCT_OR:  alu_ctrl = ALU_OR;
               FUNCT_NOR: alu_ctrl = ALU_NOR;
               FUNCT_SLT: alu_ctrl = ALU_SLT;
               default:   alu_ctrl = ALU_ILLEGAL;
            endcase
         end
         default: alu_ctrl = ALU_ILLEGAL;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// alu_exec_unit : combinational ALU, zero/overflow flags, branch gate, sticky ovf
// Revision: 1.0
// ============================================================================
module alu_exec_unit
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       alu_op,
   input  logic [5:0]       funct,
   input  logic             branch,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [3:0]       alu_ctrl,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             take_branch,
   output logic             overflow,
   output logic             ovf_sticky
);

   logic [WIDTH-1:0] w_sum;
   logic [WIDTH-1:0] w_diff;
   logic             w_add_ovf;
   logic             w_sub_ovf;
   logic             w_slt;
   logic             ovf_sticky_d;
   logic             ovf_sticky_q;

   alu_ctrl_decoder u_decoder (
      .alu_op   (alu_op),
      .funct    (funct),
      .alu_ctrl (alu_ctrl)
   );

   assign w_sum     = a + b;
   assign w_diff    = a - b;
   assign w_add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1]  != a[WIDTH-1]);
   assign w_sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);
   // Flipping the difference sign on overflow keeps SLT exact for all operand pairs
   assign w_slt     = w_diff[WIDTH-1] ^ w_sub_ovf;

   always_comb begin
      result   = '0;
      overflow = 1'b0;
      case (alu_ctrl)
         ALU_AND: result = a & b;
         ALU_OR:  result = a | b;
         ALU_NOR: result = ~(a | b);
         ALU_ADD: begin
            result   = w_sum;
            overflow = w_add_ovf;
         end
         ALU_SUB: begin
            result   = w_diff;
            overflow = w_sub_ovf;
         end
         ALU_SLT: result = {{(WIDTH-1){1'b0}}, w_slt};
         default: result = '0;
      endcase
   end

   assign zero        = (result == '0);
   assign take_branch = branch & zero;

   always_comb begin
      ovf_sticky_d = ovf_sticky_q | overflow;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_sticky_q <= 1'b0;
      end else begin
         ovf_sticky_q <= ovf_sticky_d;
      end
   end

   assign ovf_sticky = ovf_sticky_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
// tb_alu_exec_unit : directed plan vectors plus randomized checks vs a model
// Revision: 1.0
// ============================================================================
module tb_alu_exec_unit;

   localparam longint MAX_S = 64'sd2147483647;
   localparam longint MIN_S = -MAX_S - 1;

   logic        clk;
   logic        rst;
   logic [1:0]  alu_op;
   logic [5:0]  funct;
   logic        branch;
   logic [31:0] a;
   logic [31:0] b;
   logic [3:0]  alu_ctrl;
   logic [31:0] result;
   logic        zero;
   logic        take_branch;
   logic        overflow;
   logic        ovf_sticky;

   int   n_total = 0;
   int   n_bad   = 0;
   logic exp_ovf = 1'b0;
   logic model_sticky = 1'b0;

   alu_exec_unit #(.WIDTH(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .alu_op      (alu_op),
      .funct       (funct),
      .branch      (branch),
      .a           (a),
      .b           (b),
      .alu_ctrl    (alu_ctrl),
      .result      (result),
      .zero        (zero),
      .take_branch (take_branch),
      .overflow    (overflow),
      .ovf_sticky  (ovf_sticky)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h (op=%b funct=%h a=%h b=%h)", tag, got, exp, alu_op, funct, a, b);
      end
   endtask

   // Reference: signed math done in 64 bits, overflow = result out of 32-bit range
   task automatic model(input logic [1:0] op, input logic [5:0] f, input logic [31:0] x,
                        input logic [31:0] y, output logic [3:0] c, output logic [31:0] r,
                        output logic v);
      longint sx, sy, s;
      sx = $signed(x);
      sy = $signed(y);
      v  = 1'b0;
      r  = 32'h0;
      if (op == 2'd0)      c = 4'h2;
      else if (op == 2'd1) c = 4'h6;
      else if (op == 2'd3) c = 4'h1;
      else begin
         case (f)
            6'h20:   c = 4'h2;
            6'h22:   c = 4'h6;
            6'h24:   c = 4'h0;
            6'h25:   c = 4'h1;
            6'h27:   c = 4'hC;
            6'h2A:   c = 4'h7;
            default: c = 4'hF;
         endcase
      end
      case (c)
         4'h0: r = x & y;
         4'h1: r = x | y;
         4'hC: r = ~(x | y);
         4'h2: begin s = sx + sy; r = s[31:0]; v = (s > MAX_S) || (s < MIN_S); end
         4'h6: begin s = sx - sy; r = s[31:0]; v = (s > MAX_S) || (s < MIN_S); end
         4'h7: r = (sx < sy) ? 32'd1 : 32'd0;
         default: r = 32'h0;
      endcase
   endtask

   task automatic apply(input logic [1:0] op, input logic [5:0] f, input logic br,
                        input logic [31:0] x, input logic [31:0] y);
      logic [3:0]  ec;
      logic [31:0] er;
      logic        ev;
      alu_op = op;
      funct  = f;
      branch = br;
      a      = x;
      b      = y;
      model(op, f, x, y, ec, er, ev);
      exp_ovf = ev;
      #1;
      check("ctrl",   {28'h0, alu_ctrl},    {28'h0, ec});
      check("result", result,               er);
      check("zero",   {31'h0, zero},        {31'h0, (er == 32'h0)});
      check("ovf",    {31'h0, overflow},    {31'h0, ev});
      check("take",   {31'h0, take_branch}, {31'h0, br & (er == 32'h0)});
   endtask

   task automatic tick();
      @(posedge clk);
      if (!rst) model_sticky = model_sticky | exp_ovf;
      #1;
      check("sticky", {31'h0, ovf_sticky}, {31'h0, model_sticky});
   endtask

   logic [5:0]  dec_f [6];
   logic [3:0]  dec_c [6];
   logic [5:0]  ftab  [8];
   logic [31:0] corner[5];

   initial begin
      dec_f = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
      dec_c = '{4'h2,  4'h6,  4'h0,  4'h1,  4'hC,  4'h7};
      ftab  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h00, 6'h3F};
      corner = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};

      rst = 1'b1; alu_op = 2'd0; funct = 6'h0; branch = 1'b0; a = 32'h0; b = 32'h0;

      // Combinational path works while held in reset
      apply(2'd0, 6'h0, 1'b0, 32'd5, 32'd7);
      check("add5_7", result, 32'd12);
      check("add5_7_zero", {31'h0, zero}, 32'd0);
      check("rst_sticky", {31'h0, ovf_sticky}, 32'd0);

      @(negedge clk);
      rst = 1'b0;
      #1;

      for (int i = 0; i < 6; i++) begin
         apply(2'd2, dec_f[i], 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
         check("dec", {28'h0, alu_ctrl}, {28'h0, dec_c[i]});
         if (i == 2) check("and", result, 32'h00F0_00F0);
         if (i == 3) check("or",  result, 32'hFFF0_FFF0);
         if (i == 4) check("nor", result, 32'h000F_000F);
         tick();
      end

      apply(2'd2, 6'h00, 1'b1, 32'h1234_5678, 32'h1);
      check("illegal_ctrl", {28'h0, alu_ctrl}, 32'hF);
      check("illegal_res", result, 32'h0);
      check("illegal_zero", {31'h0, zero}, 32'd1);

      apply(2'd1, 6'h0, 1'b1, 32'd9, 32'd9);
      check("beq_zero", {31'h0, zero}, 32'd1);
      check("beq_take", {31'h0, take_branch}, 32'd1);
      apply(2'd1, 6'h0, 1'b0, 32'd9, 32'd9);
      check("beq_notake", {31'h0, take_branch}, 32'd0);

      apply(2'd2, 6'h2A, 1'b0, 32'hFFFF_FFFF, 32'd1);
      check("slt_neg", result, 32'd1);
      apply(2'd2, 6'h2A, 1'b0, 32'h7FFF_FFFF, 32'h8000_0000);
      check("slt_ovf", result, 32'd0);
      tick();

      apply(2'd0, 6'h0, 1'b0, 32'h7FFF_FFFF, 32'd1);
      check("ovf_res", result, 32'h8000_0000);
      check("ovf_flag", {31'h0, overflow}, 32'd1);
      tick();
      check("sticky_set", {31'h0, ovf_sticky}, 32'd1);
      apply(2'd0, 6'h0, 1'b0, 32'd1, 32'd2);
      tick();
      apply(2'd3, 6'h0, 1'b0, 32'd4, 32'd8);
      tick();
      check("sticky_hold", {31'h0, ovf_sticky}, 32'd1);

      #2;
      rst = 1'b1;
      #1;
      model_sticky = 1'b0;
      check("rst_async", {31'h0, ovf_sticky}, 32'd0);

      apply(2'd0, 6'h0, 1'b0, 32'h7FFF_FFFF, 32'd1);
      tick();
      check("rst_ovf_res", result, 32'h8000_0000);
      tick();
      check("rst_ovf_sticky", {31'h0, ovf_sticky}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;

      for (int i = 0; i < 300; i++) begin
         logic [1:0]  op;
         logic [5:0]  f;
         logic [31:0] x, y;
         op = 2'($urandom_range(0, 3));
         f  = ftab[$urandom_range(0, 7)];
         if (f == 6'h3F) f = 6'($urandom);
         x  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
         y  = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
         apply(op, f, 1'($urandom), x, y);
         if ((i % 64) == 63) begin
            rst = 1'b1;
            #1;
            model_sticky = 1'b0;
            check("rnd_rst", {31'h0, ovf_sticky}, 32'd0);
            #1;
            rst = 1'b0;
         end
         tick();
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/alu_exec_unit.md
# alu_exec_unit

Execute-stage block of the single-cycle MIPS datapath. It combines three functions:
- the ALU-control decoder, which turns the main-control ALUOp and the instruction funct field into a 4-bit operation code;
- the 32-bit ALU;
- the branch AND gate, which qualifies the control Branch flag with the ALU zero flag.

The result path is combinational, so the data memory and the register write-back mux see the result in the same cycle. The only clocked element is a sticky overflow status bit.

## Interface
Parameters:
- WIDTH, 32, operand and result width.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- alu_op  in  2  from main control. 00 = add (lw/sw), 01 = subtract (beq), 10 = R-type (decode funct), 11 = OR (ori).
- funct  in  6  instruction[5:0].
- branch  in  1  Branch flag from main control.
- a  in  WIDTH  readData1.
- b  in  WIDTH  output of the ALUSrc mux (readData2 or sign-extended immediate).
- alu_ctrl  out  4  decoded operation code, exported for visibility.
- result  out  WIDTH  ALU result.
- zero  out  1  high when result == 0.
- take_branch  out  1  branch AND zero.
- overflow  out  1  signed overflow of the current add or sub.
- ovf_sticky  out  1  registered, sticky overflow flag.

## Operation
Decoder (alu_ctrl from alu_op and funct):
- alu_op 00 → 0010 (ADD).
- alu_op 01 → 0110 (SUB).
- alu_op 11 → 0001 (OR).
- alu_op 10 decodes funct:
  - 100000 → ADD 0010
  - 100010 → SUB 0110
  - 100100 → AND 0000
  - 100101 → OR 0001
  - 100111 → NOR 1100
  - 101010 → SLT 0111
  - any other funct → 1111 (illegal).

ALU (result from alu_ctrl):
- 0000 → a & b; 0001 → a | b; 1100 → ~(a | b).
- 0010 → a + b; 0110 → a − b. Both are modulo 2^WIDTH; carry-out is discarded.
- 0111 → SLT: 1 if $signed(a) < $signed(b), else 0. The comparison must be correct even when a − b overflows.
- 1111 and any other code → result = 0.

Flags:
- zero = (result == 0). It is evaluated for every operation, including the illegal code; illegal therefore gives zero = 1.
- overflow:
  - ADD: set when the operand signs are equal and the result sign differs.
  - SUB: set when the operand signs differ and the result sign differs from a.
  - All other operations: 0.
- take_branch = branch & zero. This is pure combinational gating; alu_op is not checked.

Sticky flag:
- ovf_sticky is set to 1 on any rising clk edge where overflow = 1.
- It holds its value and is cleared only by rst.

## Timing
- alu_ctrl, result, zero, overflow and take_branch are combinational, with zero-cycle latency from any input change. They have no reset value and remain functional while rst is asserted.
- ovf_sticky is 0 immediately when rst rises, without waiting for a clock edge. It stays 0 while rst is high.
- After rst falls, the first capture of overflow happens at the next rising edge of clk.
- If rst and overflow are both high at a clock edge, rst wins and ovf_sticky stays 0.
- No handshake; every input is valid every cycle.

## Structure
- Shared package alu_pkg holds:
  - ALUOp encodings: ALUOP_ADD, ALUOP_SUB, ALUOP_RTYPE, ALUOP_OR.
  - funct constants.
  - 4-bit ALU control codes: ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR, ALU_ILLEGAL.
- One sub-module, alu_ctrl_decoder: purely combinational, taking alu_op and funct and producing alu_ctrl.
- The top level contains the ALU datapath, the zero and overflow logic, the branch AND and the ovf_sticky register.

## Test plan
- Decode: alu_op = 10 with funct 20/22/24/25/27/2A (hex) → alu_ctrl 0010/0110/0000/0001/1100/0111. funct 0x00 → 1111, result 0, zero 1.
- Arithmetic:
  - alu_op 00, a = 5, b = 7 → result 12, zero 0.
  - alu_op 01, a = 9, b = 9 → result 0, zero 1; with branch = 1, take_branch = 1; with branch = 0, take_branch = 0.
- SLT signs (alu_op 10, funct 2A):
  - a = 0xFFFFFFFF, b = 1 → result 1.
  - a = 0x7FFFFFFF, b = 0x80000000 → result 0.
- Logic: a = 0xF0F0F0F0, b = 0x0FF00FF0:
  - AND → 0x00F000F0.
  - OR → 0xFFF0FFF0.
  - NOR → 0x000F000F.
- Overflow and sticky flag:
  - ADD a = 0x7FFFFFFF, b = 1 → result 0x80000000, overflow 1. After the next clock edge, ovf_sticky = 1.
  - Then apply non-overflowing operations → ovf_sticky stays 1.
  - Assert rst between clock edges → ovf_sticky goes to 0 immediately.
- Reset with overflow present: hold rst = 1 while overflow = 1 across two clock edges → ovf_sticky stays 0, and result stays correct throughout.
